// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM request controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_ctrl_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry in-order FIFO that holds read data returned by the SRAM macro.
// Latency: a pushed word is visible at the output the cycle after the push.
// Backpressure: in_ready drops when both entries are full; a stalled head holds out_data stable.
module sram_resp_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push;
    logic              pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage, single-bit wrapping pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end
endmodule

// File: rtl/sram_req_ctrl.sv
// Request front-end for a single-port SRAM macro: post-reset zeroing sweep, then read/write issue.
// Latency: writes strobe the macro in the acceptance cycle; read data appears 2 cycles after acceptance.
// Backpressure: reads stall while buffered + in-flight reads reach 2; writes are always taken in RUN.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    input  logic [DATA_W-1:0] sram_o
);
    localparam state_t          RESET_STATE = state_t'(INIT_EN ? ST_INIT : ST_RUN);
    localparam logic [ADDR_W:0] INIT_LAST   = {1'b0, {ADDR_W{1'b1}}};

    state_t            state;
    logic [ADDR_W:0]   init_cnt;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic              fifo_in_ready;
    logic [2:0]        occupancy;
    logic              read_room;
    logic              accept;

    // Read room depends only on registered occupancy, so resp_ready never reaches req_ready.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign read_room = (occupancy < 3'd2);

    // Request handshake and macro pin drive; reset_n gating keeps every strobe idle while reset is held.
    always_comb begin
        req_ready = reset_n && (state == ST_RUN) && (req_write || read_room);
        accept    = req_valid && req_ready;
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_oeb  = 1'b1;
        sram_a    = '0;
        sram_i    = '0;
        if (reset_n && (state == ST_INIT)) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = init_cnt[ADDR_W-1:0];
        end else if (accept) begin
            sram_csb = 1'b0;
            sram_a   = req_addr;
            if (req_write) begin
                sram_web = 1'b0;
                sram_i   = req_wdata;
            end else begin
                sram_oeb = 1'b0;
            end
        end
    end

    // INIT/RUN sequencing, sweep counter, init_done and the read-in-flight flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RESET_STATE;
            init_cnt  <= '0;
            init_done <= ~INIT_EN;
            inflight  <= 1'b0;
        end else begin
            inflight <= accept && !req_write;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
            end
        end
    end

    // Macro output is valid the cycle after the read strobe; capture it then.
    sram_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (inflight),
        .in_ready  (fifo_in_ready),
        .in_data   (sram_o),
        .out_valid (resp_valid),
        .out_ready (resp_ready),
        .out_data  (resp_rdata),
        .count     (fifo_count)
    );

    // The read-room gate guarantees a free slot for every capture.
    assert property (@(posedge clock) disable iff (!reset_n) inflight |-> fifo_in_ready);
endmodule

// File: doc/sram_req_ctrl.md
SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the SRAM address width (depth = 2**ADDR_W = 256).
REQ-002 Parameter DATA_W, default 8, SHALL set the SRAM data width.
REQ-003 Parameter INIT_EN, default 1, SHALL enable the post-reset memory-zeroing sweep when 1.
REQ-004 Port clock, input, 1: the single clock; it SHALL also be the macro's CE.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port req_valid, input, 1: request offered.
REQ-007 Port req_ready, output, 1: request accepted when req_valid && req_ready at a posedge.
REQ-008 Port req_write, input, 1: 1 = write, 0 = read.
REQ-009 Port req_addr, input, ADDR_W: access address.
REQ-010 Port req_wdata, input, DATA_W: write data.
REQ-011 Port resp_valid, output, 1: read data available.
REQ-012 Port resp_ready, input, 1: consumer takes read data.
REQ-013 Port resp_rdata, output, DATA_W: read data, valid with resp_valid.
REQ-014 Port init_done, output, 1: high once the zeroing sweep is complete, or immediately after reset when INIT_EN=0.
REQ-015 Ports sram_a (ADDR_W), sram_i (DATA_W), sram_csb, sram_web, sram_oeb (1 each), all outputs: drive the macro's A, I, CSB, WEB and OEB pins; all strobes are active-low.
REQ-016 Port sram_o, input, DATA_W: macro output O, valid in the cycle after a read strobe.

Function
REQ-017 The FSM SHALL have states INIT (zeroing sweep) and RUN; reset SHALL enter INIT if INIT_EN=1, else RUN.
REQ-018 In INIT, each cycle SHALL issue a write of 0 to counter address 0..255 (sram_csb=0, sram_web=0, sram_oeb=1), hold req_ready=0, and after address 255 move to RUN with init_done=1 in the next cycle (256 cycles total).
REQ-019 In RUN with no accepted request, the block SHALL drive sram_csb=1, sram_web=1 and sram_oeb=1.
REQ-020 An accepted write SHALL drive sram_csb=0, sram_web=0, sram_oeb=1, sram_a=req_addr and sram_i=req_wdata combinationally in the acceptance cycle; no response SHALL be produced.
REQ-021 An accepted read SHALL drive sram_csb=0, sram_oeb=0 and sram_web=1 in the acceptance cycle; sram_o SHALL be captured into the response buffer on the following posedge, giving resp_valid high 2 cycles after acceptance at the earliest.
REQ-022 The response buffer SHALL be a 2-entry in-order FIFO, with an in-flight flag for a read issued in the prior cycle.
REQ-023 req_ready SHALL be 1 in RUN when req_write=1; when req_write=0 it SHALL be 1 only if (fifo_count + inflight) < 2, computed from registers only, with no combinational path from resp_ready.
REQ-024 The FIFO SHALL push and pop in the same cycle without a count change; when the FIFO is full, resp_ready=0 SHALL hold resp_rdata stable.
REQ-025 Writes SHALL be accepted even when the FIFO is full; a write and a pending read capture SHALL coexist in one cycle.
REQ-026 A read to the address written in the previous cycle SHALL return the new data (macro read-after-write ordering), with no forwarding logic.
REQ-027 The FIFO pointers SHALL wrap modulo 2; the INIT counter SHALL be ADDR_W+1 bits wide so it terminates at 256.

Reset
REQ-028 Reset (async assert, sync deassert assumed upstream) SHALL set req_ready=0, resp_valid=0, resp_rdata=0, init_done=INIT_EN?0:1, sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0, FIFO empty, inflight=0, counter=0.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered reads and restart INIT; memory contents SHALL NOT be relied upon until init_done.

Structure
REQ-030 The shared package sram_ctrl_pkg SHALL hold the state enum (ST_INIT, ST_RUN) and the ADDR_W/DATA_W defaults.
REQ-031 The response FIFO SHALL be the sub-module sram_resp_fifo (depth 2, DATA_W wide, with valid/ready on both sides).

Verification (bench instantiates the 256x8 macro on the same clock)
REQ-032 Reset with INIT_EN=1 -> init_done rises exactly 256 cycles after reset release, and reads of 0x00, 0x7F and 0xFF return 0x00.
REQ-033 Write 0xA5 to 0x3C, then read 0x3C back-to-back -> resp_rdata=0xA5 with resp_valid 2 cycles after read acceptance.
REQ-034 Hold resp_ready=0 and issue 3 reads -> 2 are accepted, the third stalls with req_ready=0; on raising resp_ready, data returns in order and the third is then accepted.
REQ-035 With the FIFO full, write 0x11 to 0x05 -> the write is accepted, and a later read of 0x05 returns 0x11.
REQ-036 Assert reset_n=0 with 2 buffered reads -> resp_valid=0 immediately, all strobes high, and INIT restarts.
REQ-037 Random 10k-operation mix checked against a scoreboard model, with resp_ready toggled 50% -> zero mismatches and no lost or duplicated responses.
